// File: rtl/step_button_conditioner_if.sv
// Button conditioner signal bundle: raw button and busy in,
// conditioned step request, debounced level and press counter out.
interface step_button_conditioner_if #(
  parameter int COUNT_W = 8
);
  logic               buttonIn;
  logic               busy;
  logic               stepPulse;
  logic               pending;
  logic               buttonLevel;
  logic [COUNT_W-1:0] pressCount;

  modport master (
    output buttonIn,
    output busy,
    input  stepPulse,
    input  pending,
    input  buttonLevel,
    input  pressCount
  );

  modport slave (
    input  buttonIn,
    input  busy,
    output stepPulse,
    output pending,
    output buttonLevel,
    output pressCount
  );
endinterface

// File: rtl/step_button_conditioner.sv
// Execute button path: 2-flop synchroniser, debounce FSM and a
// single-cycle step pulse held off by busy with one queued request.
module step_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int CNT_W           = 8,
  parameter int COUNT_W         = 8
) (
  input logic Clk,
  input logic Rst,
  step_button_conditioner_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam bit               FAST = (DEBOUNCE_CYCLES == 1);

  logic               s1_q, s2_q;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               pulse_q, pulse_d;
  logic               pend_q, pend_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s2_q) begin
          if (FAST) begin
            state_d = PRESSED;
            level_d = 1'b1;
            accept  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          accept  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          if (FAST) begin
            state_d = IDLE;
            level_d = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A pulse is always followed by a quiet cycle; anything due then waits.
  always_comb begin
    pulse_d = 1'b0;
    pend_d  = pend_q;
    if (pulse_q) begin
      pend_d = pend_q | accept;
    end else if (pend_q && !bus.busy) begin
      pulse_d = 1'b1;
      pend_d  = accept;
    end else if (accept) begin
      if (!bus.busy && !pend_q) begin
        pulse_d = 1'b1;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  assign count_d = accept ? count_q + COUNT_W'(1) : count_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      pend_q  <= 1'b0;
      count_q <= '0;
    end else begin
      s1_q    <= bus.buttonIn;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  assign bus.stepPulse   = pulse_q;
  assign bus.pending     = pend_q;
  assign bus.buttonLevel = level_q;
  assign bus.pressCount  = count_q;

endmodule
